// File: rtl/wm_pkg.sv
// Shared encodings for the word mover: operation codes and FSM states.
package wm_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD  = 2'd0;
  localparam op_t OP_STORE = 2'd1;
  localparam op_t OP_PUSH  = 2'd2;
  localparam op_t OP_POP   = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  function automatic logic is_write_op(input op_t op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/word_mover_if.sv
// Request/response and byte-RAM port bundle of the word mover.
// master: requester plus RAM model; slave: the word mover itself.
interface word_mover_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_BYTES = 2
);
  logic                    req;
  logic [1:0]              op;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [8*WORD_BYTES-1:0] wdata;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [8*WORD_BYTES-1:0] rdata;
  logic [ADDR_WIDTH-1:0]   sp;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [7:0]              dwrite;
  logic                    write_en;
  logic [7:0]              dread;

  modport master (
    output req, op, addr, wdata, dread,
    input  busy, done, err, rdata, sp, raddr, waddr, dwrite, write_en
  );

  modport slave (
    input  req, op, addr, wdata, dread,
    output busy, done, err, rdata, sp, raddr, waddr, dwrite, write_en
  );
endinterface

// File: rtl/wm_byte_sel.sv
// Combinational byte lane access: o_byte selects lane i_idx of i_word,
// o_word is i_word with lane i_idx replaced by i_byte.
module wm_byte_sel #(
  parameter int WORD_BYTES = 2
) (
  input  logic [8*WORD_BYTES-1:0] i_word,
  input  logic [1:0]              i_idx,
  input  logic [7:0]              i_byte,
  output logic [7:0]              o_byte,
  output logic [8*WORD_BYTES-1:0] o_word
);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign o_word[8*gi +: 8] = (i_idx == 2'(gi)) ? i_byte : i_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    o_byte = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i_idx == 2'(i)) o_byte = i_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/word_mover.sv
// Moves little-endian words between a requester and a byte-wide RAM (LOAD/STORE/PUSH/POP).
// Optional stack fault checks: define WORD_MOVER_STACK_CHECK_EN. RAM read latency is two clocks.
module word_mover
  import wm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WORD_BYTES  = 2,
  parameter int STACK_BYTES = 64
) (
  input logic         clk,
  input logic         rst,
  word_mover_if.slave bus
);

  localparam int                    DW  = 8 * WORD_BYTES;
  localparam logic [ADDR_WIDTH-1:0] N_A = ADDR_WIDTH'(WORD_BYTES);

  logic [1:0]            r_state;
  op_t                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]         r_wdata;
  logic [ADDR_WIDTH-1:0] r_sp;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_dwrite;
  logic                  r_write_en;
  logic                  r_err;
  logic [DW-1:0]         r_rdata;
  logic [DW-1:0]         r_rbuf;
  logic [1:0]            r_wcnt;
  logic [2:0]            r_iss;
  logic [1:0]            r_smp;
  logic [2:0]            r_vld;

  logic                  w_accept;
  logic                  w_fault;
  op_t                   w_op;
  logic [DW-1:0]         w_wr_word;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [1:0]            w_wr_step;
  logic [1:0]            w_wr_lane;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [7:0]            w_wr_byte;
  logic [2:0]            w_rd_step;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_issue;
  logic [DW-1:0]         w_rd_word;
  logic [DW-1:0]         w_unused_wr_word;
  logic [7:0]            w_unused_rd_byte;

  assign w_accept = bus.req && ((r_state == ST_IDLE) || (r_state == ST_FIN));

  // On the accept edge the first byte comes straight from the request inputs.
  assign w_op      = w_accept ? bus.op    : r_op;
  assign w_wr_word = w_accept ? bus.wdata : r_wdata;
  assign w_base    = w_accept ? bus.addr  : r_addr;
  assign w_wr_step = w_accept ? 2'd0      : r_wcnt + 2'd1;
  assign w_rd_step = w_accept ? 3'd0      : r_iss;

  assign w_wr_lane = (w_op == OP_PUSH) ? (2'(WORD_BYTES - 1) - w_wr_step) : w_wr_step;
  assign w_wr_addr = (w_op == OP_PUSH) ? (r_sp - ADDR_WIDTH'(w_wr_step))
                                       : (w_base + ADDR_WIDTH'(w_wr_step));
  assign w_rd_addr = (w_op == OP_POP)  ? (r_sp + ADDR_WIDTH'(w_rd_step) + ADDR_WIDTH'(1))
                                       : (w_base + ADDR_WIDTH'(w_rd_step));
  assign w_rd_issue = (r_iss < 3'(WORD_BYTES));

`ifdef WORD_MOVER_STACK_CHECK_EN
  logic [ADDR_WIDTH:0] w_used;
  assign w_used  = {1'b0, ~r_sp};
  assign w_fault = ((bus.op == OP_PUSH) &&
                    ((w_used + (ADDR_WIDTH+1)'(WORD_BYTES)) > (ADDR_WIDTH+1)'(STACK_BYTES))) ||
                   ((bus.op == OP_POP) && (w_used < (ADDR_WIDTH+1)'(WORD_BYTES)));
`else
  // Checks compiled out: the stack size never produces a fault.
  assign w_fault = (STACK_BYTES < 0);
`endif

  wm_byte_sel #(.WORD_BYTES(WORD_BYTES)) u_wr_sel (
    .i_word (w_wr_word),
    .i_idx  (w_wr_lane),
    .i_byte (8'h00),
    .o_byte (w_wr_byte),
    .o_word (w_unused_wr_word)
  );

  wm_byte_sel #(.WORD_BYTES(WORD_BYTES)) u_rd_sel (
    .i_word (r_rbuf),
    .i_idx  (r_smp),
    .i_byte (bus.dread),
    .o_byte (w_unused_rd_byte),
    .o_word (w_rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LOAD;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sp       <= '1;
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_dwrite   <= '0;
      r_write_en <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_rbuf     <= '0;
      r_wcnt     <= '0;
      r_iss      <= '0;
      r_smp      <= '0;
      r_vld      <= '0;
    end else begin
      r_err      <= 1'b0;
      r_write_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            if (w_fault) begin
              r_state <= ST_FIN;
              r_err   <= 1'b1;
            end else if (is_write_op(bus.op)) begin
              r_state    <= ST_WRITE;
              r_write_en <= 1'b1;
              r_waddr    <= w_wr_addr;
              r_dwrite   <= w_wr_byte;
              r_wcnt     <= 2'd0;
            end else begin
              r_state <= ST_READ;
              r_raddr <= w_rd_addr;
              r_iss   <= 3'd1;
              r_vld   <= 3'b001;
              r_smp   <= 2'd0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (r_wcnt == 2'(WORD_BYTES - 1)) begin
            r_state <= ST_FIN;
            if (r_op == OP_PUSH) r_sp <= r_sp - N_A;
          end else begin
            r_write_en <= 1'b1;
            r_waddr    <= w_wr_addr;
            r_dwrite   <= w_wr_byte;
            r_wcnt     <= w_wr_step;
          end
        end
        ST_READ: begin
          // r_vld tracks each issued address through the RAM's two-clock read pipe.
          r_vld <= {r_vld[1:0], w_rd_issue};
          if (w_rd_issue) begin
            r_raddr <= w_rd_addr;
            r_iss   <= r_iss + 3'd1;
          end
          if (r_vld[2]) begin
            r_rbuf <= w_rd_word;
            r_smp  <= r_smp + 2'd1;
            if (r_smp == 2'(WORD_BYTES - 1)) begin
              r_rdata <= w_rd_word;
              r_state <= ST_FIN;
              if (r_op == OP_POP) r_sp <= r_sp + N_A;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign bus.done     = (r_state == ST_FIN);
  assign bus.err      = r_err;
  assign bus.rdata    = r_rdata;
  assign bus.sp       = r_sp;
  assign bus.raddr    = r_raddr;
  assign bus.waddr    = r_waddr;
  assign bus.dwrite   = r_dwrite;
  assign bus.write_en = r_write_en;

endmodule

// File: doc/word_mover.md
WORD_MOVER -- requirements
Module: word_mover

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, byte-RAM address width.
REQ-002 Parameter WORD_BYTES, default 2, bytes per transfer word (legal 1..4).
REQ-003 Parameter STACK_BYTES, default 64, stack region size; the region is addresses [2^ADDR_WIDTH-STACK_BYTES, 2^ADDR_WIDTH-1].
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  1  operation request; sampled only while busy=0.
REQ-007 op  in  2  0=LOAD, 1=STORE, 2=PUSH, 3=POP.
REQ-008 addr  in  ADDR_WIDTH  base address for LOAD/STORE.
REQ-009 wdata  in  8*WORD_BYTES  word for STORE/PUSH.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  one-cycle stack fault pulse, coincident with done.
REQ-013 rdata  out  8*WORD_BYTES  word from the last successful LOAD/POP.
REQ-014 sp  out  ADDR_WIDTH  stack pointer, addressing the next free byte.
REQ-015 raddr, waddr  out  ADDR_WIDTH  RAM read/write addresses; registered.
REQ-016 dwrite  out  8, write_en  out  1, dread  in  8  RAM byte write port and read data.

Function
REQ-017 Cycle 0 is the edge at which req=1 and busy=0 are sampled; op, addr and wdata are latched at this edge; busy=1 from cycle 1.
REQ-018 Byte order is little-endian: byte i (wdata[8i+7:8i]) maps to the lower address +i; address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-019 STORE: write_en=1 in cycles 1..N (N=WORD_BYTES), writing byte k-1 at addr+k-1 in cycle k.
REQ-020 PUSH: write_en=1 in cycles 1..N, writing byte N-k at sp_old-(k-1) in cycle k; sp=sp_old-N when done.
REQ-021 LOAD: raddr=addr+k-1 in cycle k (k=1..N); dread for byte k-1 is sampled in cycle k+2.
REQ-022 POP: raddr=sp_old+k for byte k-1 (k=1..N); sp=sp_old+N when done.
REQ-023 For LOAD/POP, rdata updates in the same cycle done is asserted.
REQ-024 done=1 and busy=0 together, in cycle N+1 for writes and cycle N+3 for reads; a new req is accepted in that cycle.
REQ-025 req while busy=1 is ignored, with no queueing.
REQ-026 FSM states: IDLE, WRITE (byte counter), READ (issue/sample counters), FIN (done pulse); FIN returns to IDLE, or goes directly to WRITE/READ if req is present.
REQ-027 write_en is never asserted in IDLE, READ or FIN.

Reset
REQ-028 On rst: busy=0, done=0, err=0, write_en=0, rdata=0, raddr=0, waddr=0, dwrite=0, sp=all ones, state=IDLE.
REQ-029 rst mid-operation aborts immediately; no further writes occur and partially written bytes remain in the RAM.

Configuration
REQ-030 Macro WORD_MOVER_STACK_CHECK_EN defined:
- PUSH with (2^ADDR_WIDTH-1-sp)+N > STACK_BYTES is an overflow.
- POP with (2^ADDR_WIDTH-1-sp) < N is an underflow.
- Either fault yields done=1 and err=1 in cycle 1, with no RAM access, sp unchanged and rdata unchanged.
REQ-031 Macro undefined: no checks are made, err is tied 0, and sp wraps freely.

Structure
REQ-032 Shared package wm_pkg holds the op encodings (OP_LOAD..OP_POP) and the FSM state encodings.
REQ-033 Sub-module wm_byte_sel (combinational byte lane select/insert by index) is instantiated once for write and once for read assembly.

Verification (ADDR_WIDTH=9, WORD_BYTES=2, STACK_BYTES=64)
REQ-034 STORE addr=0x1FF, wdata=0xBEEF -> byte 0xEF written at 0x1FF and 0xBE at 0x000; done in cycle 3.
REQ-035 PUSH 0x1234 after reset, then POP -> sp goes 0x1FF→0x1FD→0x1FF; RAM[0x1FF]=0x12, RAM[0x1FE]=0x34; rdata=0x1234 in cycle 5 of the POP.
REQ-036 Back-to-back: req held high for LOAD then STORE -> STORE is accepted in the LOAD's done cycle; no idle gap.
REQ-037 With the macro: POP after reset -> err=1 and done=1 in cycle 1, sp=0x1FF; 33 PUSHes -> the 33rd raises err and sp=0x1BF.
REQ-038 rst asserted in cycle 1 of a STORE -> write_en=0 immediately, busy=0, and only the first byte is present in RAM.
